// File: rtl/lcd_rx_responder.sv
// HD44780-style LCD receive responder: synchronises the asynchronous strobe, decodes commands and data
// writes into a 32x8 DDRAM mirror, and models busy timing. Define LCD_RX_READBACK_EN to compile in bus read-back.
`timescale 1ns/1ps

module lcd_rx_responder #(
    parameter int DATA_BITS   = 8,
    parameter int BUSY_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rs,
    input  logic                 rw,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] dat_i,
    output logic [DATA_BITS-1:0] dat_o,
    output logic                 dat_oe,
    output logic                 busy,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic [6:0]           ac,
    input  logic [4:0]           rd_addr,
    output logic [7:0]           rd_char,
    output logic                 drop
);

    typedef enum logic [1:0] {
        S_CLEARING,
        S_IDLE,
        S_EXEC,
        S_BUSY
    } state_t;

    localparam int             BCW       = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [BCW-1:0] BUSY_LAST = BCW'(BUSY_CYCLES - 1);
    localparam logic [7:0]     BLANK     = 8'h20;

    // Only 0x00-0x0F (line 1) and 0x40-0x4F (line 2) have storage behind them.
    function automatic logic f_mapped(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

    function automatic logic [4:0] f_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (!f_mapped(a))      n = inc ? 7'h00 : 7'h4F;
        else if (inc) begin
            if (a == 7'h0F)      n = 7'h40;
            else if (a == 7'h4F) n = 7'h00;
            else                 n = a + 7'd1;
        end else begin
            if (a == 7'h00)      n = 7'h4F;
            else if (a == 7'h40) n = 7'h0F;
            else                 n = a - 7'd1;
        end
        return n;
    endfunction

    logic                 r_en_s1, r_en_s2, r_en_d;
    logic                 r_rs, r_rw;
    logic [DATA_BITS-1:0] r_dat;
    logic                 r_cmd_rs;
    logic [7:0]           r_cmd;
    state_t               r_state, w_state_nx;
    logic [6:0]           r_ac, w_ac_nx;
    logic                 r_id, w_id_nx;
    logic                 r_disp, w_disp_nx;
    logic                 r_cur, w_cur_nx;
    logic                 r_blink, w_blink_nx;
    logic [4:0]           r_fill, w_fill_nx;
    logic [BCW-1:0]       r_bcnt, w_bcnt_nx;
    logic                 r_drop;
    logic [7:0]           r_rd_char;
    logic [7:0]           r_ddram [32];

    logic                 w_fall, w_wr_fall, w_rd_fall;
    logic                 w_mem_we;
    logic [4:0]           w_mem_waddr;
    logic [7:0]           w_mem_wdata;

    assign w_fall    = r_en_d & ~r_en_s2;
`ifdef LCD_RX_READBACK_EN
    assign w_wr_fall = w_fall & ~r_rw;
    assign w_rd_fall = w_fall & r_rw & r_rs;
`else
    assign w_wr_fall = w_fall & ~r_rw;
    assign w_rd_fall = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEARING;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: every combinational signal is defaulted first, so no path can infer a latch.
    always_comb begin
        w_state_nx  = r_state;
        w_ac_nx     = r_ac;
        w_id_nx     = r_id;
        w_disp_nx   = r_disp;
        w_cur_nx    = r_cur;
        w_blink_nx  = r_blink;
        w_fill_nx   = r_fill;
        w_bcnt_nx   = r_bcnt;
        w_mem_we    = 1'b0;
        w_mem_waddr = f_index(r_ac);
        w_mem_wdata = r_cmd;

        // Data reads advance AC regardless of busy; an executing write below takes priority.
        if (w_rd_fall) w_ac_nx = f_step(r_ac, r_id);

        case (r_state)
            S_CLEARING: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_fill;
                w_mem_wdata = BLANK;
                if (r_fill == 5'd31) begin
                    w_fill_nx  = 5'd0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_fill_nx  = r_fill + 5'd1;
                end
            end
            S_IDLE: begin
                if (w_wr_fall) w_state_nx = S_EXEC;
            end
            S_EXEC: begin
                w_bcnt_nx  = BUSY_LAST;
                w_state_nx = S_BUSY;
                if (r_cmd_rs) begin
                    w_mem_we = f_mapped(r_ac);
                    w_ac_nx  = f_step(r_ac, r_id);
                end else begin
                    casez (r_cmd)
                        8'b1???????: w_ac_nx = r_cmd[6:0];
                        8'b01??????: ;
                        8'b001?????: ;
                        8'b0001????: if (!r_cmd[3]) w_ac_nx = f_step(r_ac, r_cmd[2]);
                        8'b00001???: begin
                            w_disp_nx  = r_cmd[2];
                            w_cur_nx   = r_cmd[1];
                            w_blink_nx = r_cmd[0];
                        end
                        8'b000001??: w_id_nx = r_cmd[1];
                        8'b0000001?: w_ac_nx = 7'h00;
                        8'b00000001: begin
                            w_ac_nx    = 7'h00;
                            w_id_nx    = 1'b1;
                            w_fill_nx  = 5'd0;
                            w_state_nx = S_CLEARING;
                        end
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (r_bcnt == '0) w_state_nx = S_IDLE;
                else              w_bcnt_nx  = r_bcnt - 1'b1;
            end
            default: w_state_nx = S_CLEARING;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en_s1   <= 1'b0;
            r_en_s2   <= 1'b0;
            r_en_d    <= 1'b0;
            r_rs      <= 1'b0;
            r_rw      <= 1'b0;
            r_dat     <= '0;
            r_cmd_rs  <= 1'b0;
            r_cmd     <= 8'h00;
            r_ac      <= 7'h00;
            r_id      <= 1'b1;
            r_disp    <= 1'b0;
            r_cur     <= 1'b0;
            r_blink   <= 1'b0;
            r_fill    <= 5'd0;
            r_bcnt    <= '0;
            r_drop    <= 1'b0;
            r_rd_char <= 8'h00;
        end else begin
            r_en_s1   <= enable;
            r_en_s2   <= r_en_s1;
            r_en_d    <= r_en_s2;
            r_rs      <= rs;
            r_rw      <= rw;
            r_dat     <= dat_i;
            if (w_wr_fall && r_state == S_IDLE) begin
                r_cmd_rs <= r_rs;
                r_cmd    <= r_dat[7:0];
            end
            r_ac      <= w_ac_nx;
            r_id      <= w_id_nx;
            r_disp    <= w_disp_nx;
            r_cur     <= w_cur_nx;
            r_blink   <= w_blink_nx;
            r_fill    <= w_fill_nx;
            r_bcnt    <= w_bcnt_nx;
            r_drop    <= w_wr_fall && (r_state != S_IDLE);
            if (w_mem_we && w_mem_waddr == rd_addr) r_rd_char <= w_mem_wdata;
            else                                    r_rd_char <= r_ddram[rd_addr];
        end
    end

    // NOTE: DDRAM has no reset; the fill that follows every reset initialises it.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_ddram[w_mem_waddr] <= w_mem_wdata;
    end

`ifdef LCD_RX_READBACK_EN
    always_comb begin
        dat_oe = r_en_s2 & r_rw;
        dat_o  = '0;
        if (dat_oe) begin
            if (r_rs) dat_o = DATA_BITS'(f_mapped(r_ac) ? r_ddram[f_index(r_ac)] : BLANK);
            else      dat_o = DATA_BITS'({busy, r_ac});
        end
    end
`else
    assign dat_o  = '0;
    assign dat_oe = 1'b0;
`endif

    assign busy       = (r_state != S_IDLE);
    assign ac         = r_ac;
    assign display_on = r_disp;
    assign cursor_on  = r_cur;
    assign blink_on   = r_blink;
    assign rd_char    = r_rd_char;
    assign drop       = r_drop;

endmodule

// File: tb/tb_lcd_rx_responder.sv
// Scoreboard bench for lcd_rx_responder: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares them against the DUT. Read-back checks follow LCD_RX_READBACK_EN.
`timescale 1ns/1ps

module tb_lcd_rx_responder;

    logic       clk = 1'b0;
    logic       reset, rs, rw, enable;
    logic [7:0] dat_i, dat_o;
    logic       dat_oe, busy, display_on, cursor_on, blink_on;
    logic [6:0] ac;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       drop;

    always #5 clk = ~clk;

    lcd_rx_responder #(.DATA_BITS(8), .BUSY_CYCLES(40)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable),
        .dat_i(dat_i), .dat_o(dat_o), .dat_oe(dat_oe), .busy(busy),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .ac(ac), .rd_addr(rd_addr), .rd_char(rd_char), .drop(drop)
    );

    typedef enum int {K_BUSY, K_AC, K_DCB, K_RDCHAR, K_DROPS, K_RDBK, K_CYC} kind_e;
    typedef struct {
        kind_e kind;
        string name;
        int    exp;
    } item_t;

    item_t       sb_q[$];
    logic        obs_req = 1'b0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          drop_cnt = 0;
    int          meas_cycles = 0;
    item_t       mon_it;
    logic [31:0] mon_act;

    always @(negedge clk) if (drop === 1'b1) drop_cnt++;

    always @(negedge clk) begin
        if (obs_req) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL scoreboard_empty: got an observation with no expected entry, required one");
            end else begin
                mon_it = sb_q.pop_front();
                case (mon_it.kind)
                    K_BUSY:   mon_act = 32'(busy);
                    K_AC:     mon_act = 32'(ac);
                    K_DCB:    mon_act = 32'({display_on, cursor_on, blink_on});
                    K_RDCHAR: mon_act = 32'(rd_char);
                    K_DROPS:  mon_act = 32'(drop_cnt);
                    K_RDBK:   mon_act = 32'({dat_oe, dat_o});
                    default:  mon_act = 32'(meas_cycles);
                endcase
                if (mon_act !== 32'(mon_it.exp)) begin
                    n_miss++;
                    $display("FAIL %s: got 0x%0h, required 0x%0h", mon_it.name, mon_act, mon_it.exp);
                end
            end
        end
    end

    task automatic expect_now(input kind_e k, input string nm, input int e);
        item_t it;
        it.kind = k;
        it.name = nm;
        it.exp  = e;
        #1;
        sb_q.push_back(it);
        obs_req = 1'b1;
        @(negedge clk);
        #1;
        obs_req = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic lcd_wr(input logic s, input logic [7:0] d);
        rs    = s;
        rw    = 1'b0;
        dat_i = d;
        strobe();
        wait_idle();
    endtask

    task automatic check_rd(input int idx, input int e, input string nm);
        rd_addr = 5'(idx);
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_now(K_RDCHAR, nm, e);
    endtask

    task automatic measure_busy();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy === 1'b1 && n < 400);
        meas_cycles = n;
    endtask

    task automatic lcd_rd_check(input logic s, input int e, input string nm);
        rs = s;
        rw = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_now(K_RDBK, nm, e);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        rw = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; rs = 1'b0; rw = 1'b0; enable = 1'b0; dat_i = 8'h00; rd_addr = 5'd0;
        repeat (3) @(posedge clk);
        expect_now(K_BUSY,  "reset_busy",   1);
        expect_now(K_AC,    "reset_ac",     0);
        expect_now(K_DCB,   "reset_dcb",    0);
        expect_now(K_RDBK,  "reset_dat_o",  0);
        expect_now(K_DROPS, "reset_drop",   0);

        @(negedge clk);
        reset = 1'b1;
        measure_busy();
        expect_now(K_CYC, "init_fill_busy_cycles", 32);
        for (int i = 0; i < 32; i++) check_rd(i, 8'h20, $sformatf("init_blank_%0d", i));

        // Init sequence, then "ABC" on line 1.
        lcd_wr(0, 8'h38); lcd_wr(0, 8'h06); lcd_wr(0, 8'h0C); lcd_wr(0, 8'h01);
        lcd_wr(1, 8'h41); lcd_wr(1, 8'h42); lcd_wr(1, 8'h43);
        check_rd(0, 8'h41, "abc_idx0");
        check_rd(1, 8'h42, "abc_idx1");
        check_rd(2, 8'h43, "abc_idx2");
        check_rd(3, 8'h20, "abc_idx3_blank");
        expect_now(K_AC,  "abc_ac",  8'h03);
        expect_now(K_DCB, "abc_dcb", 3'b100);

        // Line 1 end wraps into line 2.
        lcd_wr(0, 8'h8F); lcd_wr(1, 8'h58); lcd_wr(1, 8'h59);
        check_rd(15, 8'h58, "wrap_x_idx15");
        check_rd(16, 8'h59, "wrap_y_idx16");
        expect_now(K_AC, "wrap_ac", 8'h41);

        // Decrement from 0x00 wraps to 0x4F.
        lcd_wr(0, 8'h04); lcd_wr(0, 8'h80); lcd_wr(1, 8'h5A);
        expect_now(K_AC, "dec_wrap_ac", 8'h4F);
        check_rd(0, 8'h5A, "dec_wrap_idx0");
        lcd_wr(0, 8'h14);
        expect_now(K_AC, "shift_right_ac", 8'h00);
        lcd_wr(0, 8'h10);
        expect_now(K_AC, "shift_left_ac", 8'h4F);
        lcd_wr(0, 8'h18);
        expect_now(K_AC, "display_shift_ac", 8'h4F);

        // Unmapped AC: no store, decrement lands on 0x4F.
        lcd_wr(0, 8'hA0); lcd_wr(1, 8'h51);
        expect_now(K_AC, "unmapped_dec_ac", 8'h4F);
        check_rd(0, 8'h5A, "unmapped_idx0_kept");
        check_rd(31, 8'h20, "unmapped_idx31_kept");

        lcd_wr(0, 8'h06); lcd_wr(0, 8'hC5); lcd_wr(1, 8'h57);
        check_rd(21, 8'h57, "line2_idx21");
        expect_now(K_AC, "line2_ac", 8'h46);
        lcd_wr(0, 8'hB0); lcd_wr(1, 8'h71);
        expect_now(K_AC, "unmapped_inc_ac", 8'h00);
        lcd_wr(0, 8'hCF); lcd_wr(1, 8'h52);
        expect_now(K_AC, "inc_wrap_4f_ac", 8'h00);
        check_rd(31, 8'h52, "inc_wrap_idx31");
        lcd_wr(0, 8'h04); lcd_wr(0, 8'hC0); lcd_wr(1, 8'h53);
        expect_now(K_AC, "dec_wrap_40_ac", 8'h0F);
        check_rd(16, 8'h53, "dec_wrap_idx16");
        lcd_wr(0, 8'h06); lcd_wr(0, 8'h03);
        expect_now(K_AC, "home_ac", 8'h00);
        lcd_wr(0, 8'h0F);
        expect_now(K_DCB, "dcb_all_on", 3'b111);
        lcd_wr(0, 8'h0A);
        expect_now(K_DCB, "dcb_cursor_only", 3'b010);
        lcd_wr(0, 8'h0C);
        expect_now(K_DROPS, "no_drops_yet", 0);

        // Second write while busy is discarded.
        lcd_wr(0, 8'h80);
        rs = 1'b1; rw = 1'b0; dat_i = 8'h4D;
        strobe();
        dat_i = 8'h4E;
        strobe();
        wait_idle();
        expect_now(K_DROPS, "drop_once", 1);
        check_rd(0, 8'h4D, "drop_first_stored");
        check_rd(1, 8'h42, "drop_second_discarded");
        expect_now(K_AC, "drop_ac", 8'h01);

`ifdef LCD_RX_READBACK_EN
        rs = 1'b0; rw = 1'b0; dat_i = 8'h85;
        strobe();
        lcd_rd_check(0, 9'h185, "status_read_busy");
        wait_idle();
        lcd_rd_check(0, 9'h105, "status_read_idle");
        lcd_rd_check(1, 9'h120, "data_read_idx5");
        expect_now(K_AC,   "data_read_ac_step", 8'h06);
        expect_now(K_BUSY, "read_not_busy",     0);
`else
        lcd_rd_check(0, 0, "status_read_ignored");
        lcd_rd_check(1, 0, "data_read_ignored");
        expect_now(K_AC,   "read_ignored_ac",   8'h01);
        expect_now(K_BUSY, "read_ignored_busy", 0);
`endif

        // Reset in the middle of a clear fill restarts the full fill.
        lcd_wr(0, 8'hC4); lcd_wr(1, 8'h4B);
        check_rd(20, 8'h4B, "pre_clear_idx20");
        lcd_wr(0, 8'h0F);
        rs = 1'b0; rw = 1'b0; dat_i = 8'h01;
        strobe();
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_now(K_BUSY, "midclear_reset_busy", 1);
        expect_now(K_AC,   "midclear_reset_ac",   0);
        expect_now(K_DCB,  "midclear_reset_dcb",  0);
        @(negedge clk);
        reset = 1'b1;
        measure_busy();
        expect_now(K_CYC, "refill_busy_cycles", 32);
        check_rd(20, 8'h20, "refill_idx20");
        check_rd(0,  8'h20, "refill_idx0");

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
